pipeline_issue_arbiter: RTL and testbench

Sits at the head of the `pipeline_stage` chain and shares it between `NUM_REQ` requesters. Each cycle it grants one requester round-robin and allocates a free transaction ID, then injects address and ID into the first stage, honouring that stage's stall. It retires IDs when transactions leave the last stage and reports completion to the owning requester. On request it sequences a flush: it drives the flush broadcast, quarantines the ID until the pipeline has drained, then frees the ID.

---
 rtl/pipeline_issue_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pipeline_issue_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_arbiter.sv
// -----------------------------------------------------------------------------
// pipeline_issue_arbiter
//
// Shares the head of a pipeline_stage chain between NUM_REQ requesters. Each
// cycle one requester is granted round-robin, a free transaction ID is taken
// from the pool and address + ID are injected into stage 0 (unless stage 0
// stalls). IDs are retired when transactions leave the last stage and the
// completion is reported back with the owning requester. A flush request
// broadcasts a cancel for one ID, quarantines it while the chain drains, then
// frees it.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_valid/req_address   per-requester request, address i at [i*AW +: AW]
//   req_ready/req_id        one-hot grant and allocated ID (combinational)
//   flush_req/flush_id      level request to cancel one in-flight ID
//   flush_ack/flush_err     completion pulse; err = ID was not in flight
//   pipe_address/id/valid   stage 0 inputs
//   pipe_stall              stage 0 stall
//   pipe_flush/flush_id     stage 0 flush broadcast
//   ret_valid/ret_id        last-stage output
//   done_valid/id/owner     registered completion report
//   inflight_count          registered number of allocated IDs
//   err_spurious            sticky: retire of an unallocated ID
// -----------------------------------------------------------------------------
module pipeline_issue_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PIPE_DEPTH    = 4,
    parameter int ADDRESS_WIDTH = 16,
    parameter int ID_WIDTH      = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ID_WIDTH-1:0]              req_id,
    input  logic                             flush_req,
    input  logic [ID_WIDTH-1:0]              flush_id,
    output logic                             flush_ack,
    output logic                             flush_err,
    output logic [ADDRESS_WIDTH-1:0]         pipe_address,
    output logic [ID_WIDTH-1:0]              pipe_id,
    output logic                             pipe_valid,
    input  logic                             pipe_stall,
    output logic                             pipe_flush,
    output logic [ID_WIDTH-1:0]              pipe_flush_id,
    input  logic                             ret_valid,
    input  logic [ID_WIDTH-1:0]              ret_id,
    output logic                             done_valid,
    output logic [ID_WIDTH-1:0]              done_id,
    output logic [$clog2(NUM_REQ)-1:0]       done_owner,
    output logic [ID_WIDTH:0]                inflight_count,
    output logic                             err_spurious
);

    localparam int NUM_IDS = 1 << ID_WIDTH;
    localparam int OWN_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(PIPE_DEPTH + 1);
    localparam int CW      = ID_WIDTH + 1;

    localparam logic [ID_WIDTH-1:0]      ID_ZERO   = '0;
    localparam logic [OWN_W-1:0]         OWN_ZERO  = '0;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [NUM_REQ-1:0]       REQ_ZERO  = '0;
    localparam logic [NUM_REQ-1:0]       REQ_ONE   = NUM_REQ'(1);
    localparam logic [CNT_W-1:0]         CNT_ZERO  = '0;
    localparam logic [NUM_IDS-1:0]       IDS_ZERO  = '0;
    localparam logic [CW-1:0]            CW_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_r, state_next_s;
    logic [CNT_W-1:0]          drain_cnt_r, drain_cnt_next_s;
    logic [ID_WIDTH-1:0]       flush_id_r, flush_id_next_s;
    logic [NUM_IDS-1:0]        inflight_r, inflight_next_s;
    logic [OWN_W-1:0]          owner_r [NUM_IDS];
    logic [OWN_W-1:0]          rr_r;
    logic [CW-1:0]             count_r, count_next_s;
    logic                      done_valid_r;
    logic [ID_WIDTH-1:0]       done_id_r;
    logic [OWN_W-1:0]          done_owner_r;
    logic                      flush_ack_r, flush_err_r;
    logic                      err_spurious_r;

    logic                      free_found_s;
    logic [ID_WIDTH-1:0]       free_id_s;
    logic                      grant_found_s;
    logic [OWN_W-1:0]          grant_idx_s;
    logic [ADDRESS_WIDTH-1:0]  grant_addr_s;
    logic                      issue_en_s;
    logic                      ret_in_flight_s, ret_drop_s, ret_ok_s, ret_spur_s;
    logic                      ack_next_s, err_next_s, flush_done_s;

    // Lowest-numbered free ID in the registered bitmap (scan high to low so the lowest wins).
    always_comb begin
        free_found_s = 1'b0;
        free_id_s    = ID_ZERO;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (!inflight_r[i]) begin
                free_found_s = 1'b1;
                free_id_s    = ID_WIDTH'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Round-robin pick: first valid requester at index >= rr, wrapping.
    always_comb begin
        int               cand_v;
        logic [OWN_W-1:0] cand_idx_v;
        grant_found_s = 1'b0;
        grant_idx_s   = OWN_ZERO;
        cand_v        = 0;
        cand_idx_v    = OWN_ZERO;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_v = int'(rr_r) + k;
            if (cand_v >= NUM_REQ) begin
                cand_v = cand_v - NUM_REQ;
            end else begin
                cand_v = cand_v;
            end
            cand_idx_v = OWN_W'(cand_v);
            if (!grant_found_s && req_valid[cand_idx_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Address of the granted requester.
    always_comb begin
        grant_addr_s = ADDR_ZERO;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (OWN_W'(k) == grant_idx_s) begin
                grant_addr_s = req_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end else begin
                grant_addr_s = grant_addr_s;
            end
        end
    end

    // reset_n gates issue so the combinational grant outputs are quiet during reset.
    assign issue_en_s = reset_n && (state_r == ST_IDLE) && !pipe_stall
                        && grant_found_s && free_found_s;

    // Grant / issue outputs, all zero when not issuing.
    always_comb begin
        req_ready    = REQ_ZERO;
        req_id       = ID_ZERO;
        pipe_valid   = 1'b0;
        pipe_address = ADDR_ZERO;
        pipe_id      = ID_ZERO;
        if (issue_en_s) begin
            req_ready    = REQ_ONE << grant_idx_s;
            req_id       = free_id_s;
            pipe_valid   = 1'b1;
            pipe_address = grant_addr_s;
            pipe_id      = free_id_s;
        end else begin
            req_ready    = REQ_ZERO;
        end
    end

    assign pipe_flush    = (state_r == ST_FLUSH);
    assign pipe_flush_id = (state_r == ST_FLUSH) ? flush_id_r : ID_ZERO;

    // A retire of the ID under flush is a stale entry ahead of the flush wave: dropped quietly.
    assign ret_in_flight_s = inflight_r[ret_id];
    assign ret_drop_s = ret_valid && ret_in_flight_s && (state_r != ST_IDLE) && (ret_id == flush_id_r);
    assign ret_ok_s   = ret_valid && ret_in_flight_s && !ret_drop_s;
    assign ret_spur_s = ret_valid && !ret_in_flight_s;

    // Flush FSM next state. DRAIN is loaded with PIPE_DEPTH-1 so it lasts PIPE_DEPTH cycles,
    // which puts the registered ack PIPE_DEPTH+1 cycles after pipe_flush.
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        flush_id_next_s  = flush_id_r;
        ack_next_s       = 1'b0;
        err_next_s       = 1'b0;
        flush_done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    if (inflight_r[flush_id]) begin
                        flush_id_next_s = flush_id;
                        state_next_s    = ST_FLUSH;
                    end else begin
                        ack_next_s = 1'b1;
                        err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_next_s     = ST_DRAIN;
                drain_cnt_next_s = CNT_W'(PIPE_DEPTH - 1);
            end
            ST_DRAIN: begin
                if (drain_cnt_r == CNT_ZERO) begin
                    flush_done_s = 1'b1;
                    ack_next_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    drain_cnt_next_s = drain_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                drain_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    // Next inflight bitmap and count; allocate and free never target the same ID.
    always_comb begin
        inflight_next_s = inflight_r;
        if (issue_en_s) begin
            inflight_next_s[free_id_s] = 1'b1;
        end else begin
            inflight_next_s = inflight_next_s;
        end
        if (ret_ok_s) begin
            inflight_next_s[ret_id] = 1'b0;
        end else begin
            inflight_next_s = inflight_next_s;
        end
        if (flush_done_s) begin
            inflight_next_s[flush_id_r] = 1'b0;
        end else begin
            inflight_next_s = inflight_next_s;
        end
        count_next_s = count_r + CW'(issue_en_s) - CW'(ret_ok_s) - CW'(flush_done_s);
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= CNT_ZERO;
            flush_id_r  <= ID_ZERO;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            flush_id_r  <= flush_id_next_s;
        end
    end

    // ID pool, owner table, round-robin pointer and count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= IDS_ZERO;
            count_r    <= CW_ZERO;
            rr_r       <= OWN_ZERO;
            for (int i = 0; i < NUM_IDS; i++) begin
                owner_r[i] <= OWN_ZERO;
            end
        end else begin
            inflight_r <= inflight_next_s;
            count_r    <= count_next_s;
            if (issue_en_s) begin
                owner_r[free_id_s] <= grant_idx_s;
                rr_r <= (grant_idx_s == OWN_W'(NUM_REQ - 1)) ? OWN_ZERO : grant_idx_s + OWN_W'(1);
            end else begin
                rr_r <= rr_r;
            end
        end
    end

    // Registered completion, flush-ack and error reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_valid_r   <= 1'b0;
            done_id_r      <= ID_ZERO;
            done_owner_r   <= OWN_ZERO;
            flush_ack_r    <= 1'b0;
            flush_err_r    <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            done_valid_r   <= ret_ok_s;
            done_id_r      <= ret_ok_s ? ret_id : ID_ZERO;
            done_owner_r   <= ret_ok_s ? owner_r[ret_id] : OWN_ZERO;
            flush_ack_r    <= ack_next_s;
            flush_err_r    <= err_next_s;
            err_spurious_r <= err_spurious_r | ret_spur_s;
        end
    end

    assign done_valid     = done_valid_r;
    assign done_id        = done_id_r;
    assign done_owner     = done_owner_r;
    assign flush_ack      = flush_ack_r;
    assign flush_err      = flush_err_r;
    assign inflight_count = count_r;
    assign err_spurious   = err_spurious_r;

endmodule

// File: tb/tb_pipeline_issue_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_issue_arbiter (NUM_REQ=4, PIPE_DEPTH=4, AW=8, IDW=2).
// A cycle table drives inputs after the falling edge and checks every output
// 1 ns later; hand-written sequences cover flush rejection and reset mid-drain.
// -----------------------------------------------------------------------------
module tb_pipeline_issue_arbiter;

    localparam int NR  = 4;
    localparam int PD  = 4;
    localparam int AW  = 8;
    localparam int IDW = 2;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_address;
    logic [NR-1:0]    req_ready;
    logic [IDW-1:0]   req_id;
    logic             flush_req;
    logic [IDW-1:0]   flush_id;
    logic             flush_ack;
    logic             flush_err;
    logic [AW-1:0]    pipe_address;
    logic [IDW-1:0]   pipe_id;
    logic             pipe_valid;
    logic             pipe_stall;
    logic             pipe_flush;
    logic [IDW-1:0]   pipe_flush_id;
    logic             ret_valid;
    logic [IDW-1:0]   ret_id;
    logic             done_valid;
    logic [IDW-1:0]   done_id;
    logic [1:0]       done_owner;
    logic [IDW:0]     inflight_count;
    logic             err_spurious;

    int checks;
    int failures;

    pipeline_issue_arbiter #(
        .NUM_REQ(NR), .PIPE_DEPTH(PD), .ADDRESS_WIDTH(AW), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_address(req_address),
        .req_ready(req_ready), .req_id(req_id),
        .flush_req(flush_req), .flush_id(flush_id),
        .flush_ack(flush_ack), .flush_err(flush_err),
        .pipe_address(pipe_address), .pipe_id(pipe_id), .pipe_valid(pipe_valid),
        .pipe_stall(pipe_stall),
        .pipe_flush(pipe_flush), .pipe_flush_id(pipe_flush_id),
        .ret_valid(ret_valid), .ret_id(ret_id),
        .done_valid(done_valid), .done_id(done_id), .done_owner(done_owner),
        .inflight_count(inflight_count), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;   logic st;   logic rtv;  logic [1:0] rti;
        logic fr;         logic [1:0] fi;
        logic [3:0] er;   logic [1:0] eid; logic epv; logic [7:0] epa;
        logic epf;        logic [1:0] epfid;
        logic edv;        logic [1:0] edid; logic [1:0] edo;
        logic [2:0] ecnt; logic eack; logic eerr; logic esp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [3:0] rv, input logic st, input logic rtv, input logic [1:0] rti,
        input logic fr, input logic [1:0] fi,
        input logic [3:0] er, input logic [1:0] eid, input logic epv, input logic [7:0] epa,
        input logic epf, input logic [1:0] epfid,
        input logic edv, input logic [1:0] edid, input logic [1:0] edo,
        input logic [2:0] ecnt, input logic eack, input logic eerr, input logic esp);
        vec_t v;
        v.rv = rv; v.st = st; v.rtv = rtv; v.rti = rti; v.fr = fr; v.fi = fi;
        v.er = er; v.eid = eid; v.epv = epv; v.epa = epa; v.epf = epf; v.epfid = epfid;
        v.edv = edv; v.edid = edid; v.edo = edo; v.ecnt = ecnt;
        v.eack = eack; v.eerr = eerr; v.esp = esp;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic check_all_zero(input int row);
        check("rst_req_ready", row, 32'(req_ready), 32'd0);
        check("rst_req_id", row, 32'(req_id), 32'd0);
        check("rst_pipe_valid", row, 32'(pipe_valid), 32'd0);
        check("rst_pipe_address", row, 32'(pipe_address), 32'd0);
        check("rst_pipe_id", row, 32'(pipe_id), 32'd0);
        check("rst_pipe_flush", row, 32'(pipe_flush), 32'd0);
        check("rst_pipe_flush_id", row, 32'(pipe_flush_id), 32'd0);
        check("rst_flush_ack", row, 32'(flush_ack), 32'd0);
        check("rst_flush_err", row, 32'(flush_err), 32'd0);
        check("rst_done_valid", row, 32'(done_valid), 32'd0);
        check("rst_done_id", row, 32'(done_id), 32'd0);
        check("rst_done_owner", row, 32'(done_owner), 32'd0);
        check("rst_inflight_count", row, 32'(inflight_count), 32'd0);
        check("rst_err_spurious", row, 32'(err_spurious), 32'd0);
    endtask

    initial begin
        vec_t v;
        bit   got_ack;
        checks      = 0;
        failures    = 0;
        req_address = {8'h40, 8'h30, 8'h20, 8'h10};
        reset_n     = 1'b0;
        req_valid   = 4'b1111;
        pipe_stall  = 1'b0;
        ret_valid   = 1'b0;
        ret_id      = 2'd0;
        flush_req   = 1'b0;
        flush_id    = 2'd0;

        // Reset state, with requests pending
        repeat (2) @(negedge clk);
        #1;
        check_all_zero(0);
        @(negedge clk);
        req_valid = 4'b0000;
        reset_n   = 1'b1;

        // rv st rtv rti fr fi | ready id pv pa pf pfid | dv did down | cnt ack err spur
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0001,2'd0,1'b1,8'h10,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0100,2'd1,1'b1,8'h30,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0001,2'd2,1'b1,8'h10,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0100,2'd3,1'b1,8'h30,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd3,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd4,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b1,2'd2,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd4,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0101,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0001,2'd2,1'b1,8'h10,1'b0,2'd0, 1'b1,2'd2,2'd0, 3'd3,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b1,2'd1,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd4,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b1,2'd3,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b1,2'd1,2'd2, 3'd3,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b1,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b1,2'd3,2'd2, 3'd2,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b1,2'd2,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b1,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b1,2'd2,2'd0, 3'd0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd0,1'b0,1'b0,1'b0));
        // stall window with requester 1 pending
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0001,2'd0,1'b1,8'h10,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0010,1'b1,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0010,1'b1,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0010,1'b1,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0010,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0010,2'd1,1'b1,8'h20,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b0));
        // spurious retire of ID 3
        tbl.push_back(mk(4'b0000,1'b0,1'b1,2'd3,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b0));
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        // flush ID 1; requester 0 blocked; retire of ID 1 during DRAIN dropped
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b1,2'd1, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b1,2'd1,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b1,2'd1, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));
        tbl.push_back(mk(4'b0001,1'b0,1'b0,2'd0,1'b0,2'd1, 4'b0001,2'd1,1'b1,8'h10,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd1,1'b1,1'b0,1'b1));
        tbl.push_back(mk(4'b0000,1'b0,1'b0,2'd0,1'b0,2'd0, 4'b0000,2'd0,1'b0,8'h00,1'b0,2'd0, 1'b0,2'd0,2'd0, 3'd2,1'b0,1'b0,1'b1));

        foreach (tbl[r]) begin
            v = tbl[r];
            @(negedge clk);
            req_valid  = v.rv;
            pipe_stall = v.st;
            ret_valid  = v.rtv;
            ret_id     = v.rti;
            flush_req  = v.fr;
            flush_id   = v.fi;
            #1;
            check("req_ready", r, 32'(req_ready), 32'(v.er));
            check("req_id", r, 32'(req_id), 32'(v.eid));
            check("pipe_valid", r, 32'(pipe_valid), 32'(v.epv));
            check("pipe_address", r, 32'(pipe_address), 32'(v.epa));
            check("pipe_id", r, 32'(pipe_id), 32'(v.eid));
            check("pipe_flush", r, 32'(pipe_flush), 32'(v.epf));
            check("pipe_flush_id", r, 32'(pipe_flush_id), 32'(v.epfid));
            check("done_valid", r, 32'(done_valid), 32'(v.edv));
            check("done_id", r, 32'(done_id), 32'(v.edid));
            check("done_owner", r, 32'(done_owner), 32'(v.edo));
            check("inflight_count", r, 32'(inflight_count), 32'(v.ecnt));
            check("flush_ack", r, 32'(flush_ack), 32'(v.eack));
            check("flush_err", r, 32'(flush_err), 32'(v.eerr));
            check("err_spurious", r, 32'(err_spurious), 32'(v.esp));
        end

        // Flush of a non-allocated ID: ack+err next cycle, never a pipe_flush.
        @(negedge clk);
        req_valid = 4'b0000; ret_valid = 1'b0; pipe_stall = 1'b0;
        flush_req = 1'b1; flush_id = 2'd3;
        #1;
        check("rej_pipe_flush_req", 100, 32'(pipe_flush), 32'd0);
        check("rej_ack_early", 100, 32'(flush_ack), 32'd0);
        @(negedge clk);
        #1;
        check("rej_flush_ack", 101, 32'(flush_ack), 32'd1);
        check("rej_flush_err", 101, 32'(flush_err), 32'd1);
        check("rej_pipe_flush", 101, 32'(pipe_flush), 32'd0);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        check("rej_ack_pulse", 102, 32'(flush_ack), 32'd0);
        check("rej_pipe_flush_after", 102, 32'(pipe_flush), 32'd0);
        check("rej_count", 102, 32'(inflight_count), 32'd2);

        // Flush ID 0, wait for pipe_flush (bounded), then reset in the middle of DRAIN.
        @(negedge clk);
        flush_req = 1'b1; flush_id = 2'd0;
        got_ack = 1'b0;
        for (int n = 0; n < 4 && !got_ack; n++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            if (pipe_flush) got_ack = 1'b1;
        end
        check("rst_seq_pipe_flush_seen", 110, 32'(got_ack), 32'd1);
        check("rst_seq_pipe_flush_id", 110, 32'(pipe_flush_id), 32'd0);
        check("rst_seq_blocked", 110, 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("drain_blocked", 111, 32'(req_ready), 32'd0);
        check("drain_pipe_flush", 111, 32'(pipe_flush), 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero(112);
        flush_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 113, 32'(req_ready), 32'b0001);
        check("post_rst_id", 113, 32'(req_id), 32'd0);
        check("post_rst_addr", 113, 32'(pipe_address), 32'h10);
        check("post_rst_count", 113, 32'(inflight_count), 32'd0);
        check("post_rst_flush_ack", 113, 32'(flush_ack), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_ready2", 114, 32'(req_ready), 32'b0010);
        check("post_rst_id2", 114, 32'(req_id), 32'd1);
        check("post_rst_count2", 114, 32'(inflight_count), 32'd1);
        req_valid = 4'b0000;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
